// File: rtl/lcd_rx_monitor_if.sv
// LCD bus as seen on the panel connector: enable strobe, register select,
// read/write and the 4-bit data nibble. The display driver (or a bench)
// owns the master side; the receive monitor listens on the slave side.
interface lcd_rx_monitor_if;
    logic       LCDE;
    logic       LCDRS;
    logic       LCDRW;
    logic [3:0] LCDDAT;

    modport master (output LCDE, LCDRS, LCDRW, LCDDAT);
    modport slave  (input  LCDE, LCDRS, LCDRW, LCDDAT);
endinterface

// File: rtl/lcd_rx_monitor.sv
// Receive-side model of a 4-bit HD44780-style LCD bus. Nibble strobes are
// reassembled into command/data bytes, and the 2x16 screen is rebuilt as a
// 256-bit string (line0 col0 in [255:248], line1 col0 in [127:120]).
module lcd_rx_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int NIB_TIMEOUT = 1000000
) (
    input  logic                CCLK,
    input  logic                RSTN,
    lcd_rx_monitor_if.slave     lcd,
    output logic [255:0]        disp_str,
    output logic                byte_vld,
    output logic [7:0]          byte_out,
    output logic                byte_rs,
    output logic                mode4,
    output logic [6:0]          ddram_addr,
    output logic                rd_err,
    output logic                sync_err
);

    localparam int                CNT_W   = $clog2(NIB_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_MAX = CNT_W'(NIB_TIMEOUT);
    localparam logic [255:0]      BLANK   = {32{8'h20}};

    typedef enum logic [1:0] {ST_INIT8, ST_HI, ST_LO} state_t;

    // {E, RS, RW, DAT[3:0]} travel together so they are sampled coherently.
    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  smp;
    logic                        e_last;
    logic                        strobe_c;
    logic                        stb_q;
    logic                        stb_rs;
    logic                        stb_rw;
    logic [3:0]                  stb_dat;
    logic                        wr_stb;

    state_t                      state, state_nxt;
    logic [3:0]                  hi_nib;
    logic                        hi_rs;
    logic [CNT_W-1:0]            tmo_cnt;
    logic                        inc_mode;
    logic [7:0]                  byte_c;
    logic                        take_hi, take_byte, timeout, go_mode4;
    logic                        bank0, bank1;
    logic [4:0]                  pos;

    assign smp      = sync_q[SYNC_STAGES-1];
    assign strobe_c = e_last & ~smp[6];
    assign wr_stb   = stb_q & ~stb_rw;
    assign byte_c   = {hi_nib, stb_dat};
    assign bank0    = (ddram_addr[6:4] == 3'b000);
    assign bank1    = (ddram_addr[6:4] == 3'b100);
    assign pos      = {bank1, ddram_addr[3:0]};

    // DDRAM address step with the two-line wrap points of a 2x40 DDRAM.
    function automatic logic [6:0] adv_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h40) return 7'h27;
        if (a == 7'h00) return 7'h67;
        return a - 7'd1;
    endfunction

    // Synchronize the bus and register the falling-edge strobe with its fields.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q  <= '0;
            e_last  <= 1'b0;
            stb_q   <= 1'b0;
            stb_rs  <= 1'b0;
            stb_rw  <= 1'b0;
            stb_dat <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value of its neighbour, which is what makes this a shift chain.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], {lcd.LCDE, lcd.LCDRS, lcd.LCDRW, lcd.LCDDAT}};
            e_last  <= smp[6];
            stb_q   <= strobe_c;
            stb_rs  <= smp[5];
            stb_rw  <= smp[4];
            stb_dat <= smp[3:0];
        end
    end

    // State register.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) state <= ST_INIT8;
        else       state <= state_nxt;
    end

    // Next-state and per-cycle actions of the nibble assembler.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        state_nxt = state;
        take_hi   = 1'b0;
        take_byte = 1'b0;
        timeout   = 1'b0;
        go_mode4  = 1'b0;
        unique case (state)
            ST_INIT8: begin
                if (wr_stb && !stb_rs && stb_dat == 4'h2) begin
                    go_mode4  = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (wr_stb) begin
                    take_hi   = 1'b1;
                    state_nxt = ST_LO;
                end
            end
            ST_LO: begin
                if (wr_stb) begin
                    take_byte = 1'b1;
                    // Function set with DL=1 drops the bus back to 8-bit init.
                    state_nxt = (!hi_rs && byte_c[7:4] == 4'b0011) ? ST_INIT8 : ST_HI;
                end else if (tmo_cnt == TMO_MAX) begin
                    timeout   = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            default: state_nxt = ST_INIT8;
        endcase
    end

    // Byte output, command decode, screen image and error flags.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            // NOTE: the screen image is a plain register vector, so it can and must be reset to blanks.
            disp_str   <= BLANK;
            byte_vld   <= 1'b0;
            byte_out   <= 8'h00;
            byte_rs    <= 1'b0;
            mode4      <= 1'b0;
            ddram_addr <= 7'h00;
            rd_err     <= 1'b0;
            sync_err   <= 1'b0;
            inc_mode   <= 1'b1;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (stb_q && stb_rw) rd_err <= 1'b1;
            if (timeout) sync_err <= 1'b1;
            if (go_mode4) mode4 <= 1'b1;

            if (take_hi) begin
                hi_nib  <= stb_dat;
                hi_rs   <= stb_rs;
                tmo_cnt <= '0;
            end else if (state == ST_LO && tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (take_byte) begin
                byte_vld <= 1'b1;
                byte_out <= byte_c;
                byte_rs  <= hi_rs;
                if (!hi_rs) begin
                    casez (byte_c)
                        8'b1???????: ddram_addr <= byte_c[6:0];
                        8'b001?????: if (byte_c[4]) mode4 <= 1'b0;
                        8'b000001??: inc_mode <= byte_c[1];
                        8'b0000001?: ddram_addr <= 7'h00;
                        8'b00000001: begin
                            disp_str   <= BLANK;
                            ddram_addr <= 7'h00;
                            inc_mode   <= 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    if (bank0 || bank1) disp_str[{~pos, 3'b000} +: 8] <= byte_c;
                    ddram_addr <= adv_addr(ddram_addr, inc_mode);
                end
            end
        end
    end

endmodule
